// File: rtl/jt12_eg_mon_if.sv
// Read handshake between a CPU/debug master and the envelope monitor.
interface jt12_eg_mon_if;
    logic       req;
    logic [4:0] req_slot;
    logic       ack;
    logic [9:0] rd_eg;
    logic       rd_err;

    modport master (
        output req,
        output req_slot,
        input  ack,
        input  rd_eg,
        input  rd_err
    );

    modport slave (
        input  req,
        input  req_slot,
        output ack,
        output rd_eg,
        output rd_err
    );
endinterface

// File: rtl/jt12_eg_mon.sv
// Envelope-output monitor: tracks slot position of the 24-slot eg_V stream,
// keeps a per-slot silent mask and serves single-slot attenuation reads.
module jt12_eg_mon #(
    parameter int unsigned SLOT_OFS  = 0,
    parameter logic [9:0]  SILENT_TH = 10'h3F0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic               zero,
    input  logic [9:0]         eg_V,
    jt12_eg_mon_if.slave       rd,
    output logic               synced,
    output logic               sync_err,
    output logic [23:0]        silent
);

    localparam int unsigned NSLOT = 24;
    localparam int unsigned SW    = 5;
    localparam int unsigned EW    = 10;
    localparam logic [SW-1:0] LAST_SLOT = SW'(NSLOT - 1);
    localparam logic [SW-1:0] OFS       = SW'(SLOT_OFS % NSLOT);
    // Local slots at or above WRAP_AT land past 23 once offset, so they wrap.
    localparam logic [SW-1:0] WRAP_AT   = SW'(NSLOT - (SLOT_OFS % NSLOT));
    localparam logic [EW-1:0] EG_MAX    = {EW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [SW-1:0]   cnt;
    logic [SW-1:0]   sel;
    logic [SW-1:0]   sel_nx;
    logic            ack_q;
    logic            ack_nx;
    logic [EW-1:0]   rd_eg_q;
    logic [EW-1:0]   rd_eg_nx;
    logic            rd_err_q;
    logic            rd_err_nx;

    logic [SW-1:0]   ls_c;
    logic [SW-1:0]   ts_c;
    logic            live_c;
    logic            beat_c;
    logic            hit_c;

    // Slot decode for the current beat; a zero marker forces local slot 0.
    always_comb begin
        ls_c   = zero ? '0 : cnt;
        ts_c   = (ls_c >= WRAP_AT) ? SW'(ls_c - WRAP_AT) : SW'(ls_c + OFS);
        live_c = synced | zero;
        beat_c = clk_en & live_c;
        hit_c  = beat_c & (ts_c == sel);
    end

    // Slot counter, sync tracking and silent mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            synced   <= 1'b0;
            sync_err <= 1'b0;
            silent   <= {NSLOT{1'b1}};
        end else begin
            sync_err <= 1'b0;
            if (clk_en) begin
                cnt <= (ls_c == LAST_SLOT) ? '0 : SW'(ls_c + SW'(1));
                if (zero) begin
                    synced <= 1'b1;
                    if (synced && (cnt != '0))
                        sync_err <= 1'b1;
                end
                if (live_c)
                    silent[ts_c] <= (eg_V >= SILENT_TH);
            end
        end
    end

    // Read FSM state and read-side result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sel      <= '0;
            ack_q    <= 1'b0;
            rd_eg_q  <= '0;
            rd_err_q <= 1'b0;
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            ack_q    <= ack_nx;
            rd_eg_q  <= rd_eg_nx;
            rd_err_q <= rd_err_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (rd.req)
                    state_nx = (rd.req_slot > LAST_SLOT) ? S_ACK : S_WAIT;
            end
            S_WAIT: begin
                if (!rd.req)
                    state_nx = S_IDLE;
                else if (hit_c)
                    state_nx = S_ACK;
            end
            S_ACK: begin
                if (!rd.req)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Next values of the registered read outputs.
    always_comb begin
        sel_nx    = sel;
        ack_nx    = ack_q;
        rd_eg_nx  = rd_eg_q;
        rd_err_nx = rd_err_q;
        case (state)
            S_IDLE: begin
                ack_nx = 1'b0;
                if (rd.req) begin
                    sel_nx = rd.req_slot;
                    if (rd.req_slot > LAST_SLOT) begin
                        rd_eg_nx  = EG_MAX;
                        rd_err_nx = 1'b1;
                        ack_nx    = 1'b1;
                    end else begin
                        rd_err_nx = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                if (!rd.req) begin
                    ack_nx = 1'b0;
                end else if (hit_c) begin
                    rd_eg_nx = eg_V;
                    ack_nx   = 1'b1;
                end
            end
            S_ACK: begin
                if (!rd.req)
                    ack_nx = 1'b0;
            end
            default: ack_nx = 1'b0;
        endcase
    end

    assign rd.ack    = ack_q;
    assign rd.rd_eg  = rd_eg_q;
    assign rd.rd_err = rd_err_q;

endmodule

// File: tb/tb_jt12_eg_mon.sv
// Directed bench for jt12_eg_mon: two instances (SLOT_OFS 0 and 3) share one stream.
module tb_jt12_eg_mon;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        zero;
    logic [9:0]  eg_V;
    logic        synced0, synced3;
    logic        sync_err0, sync_err3;
    logic [23:0] silent0, silent3;

    jt12_eg_mon_if bus0 ();
    jt12_eg_mon_if bus3 ();

    jt12_eg_mon dut0 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .zero(zero), .eg_V(eg_V),
        .rd(bus0), .synced(synced0), .sync_err(sync_err0), .silent(silent0)
    );

    jt12_eg_mon #(.SLOT_OFS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .zero(zero), .eg_V(eg_V),
        .rd(bus3), .synced(synced3), .sync_err(sync_err3), .silent(silent3)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0] eg_tbl [24];
    int  gslot     = 0;
    bit  phase     = 0;
    bit  stream_on = 0;
    bit  pause     = 0;
    bit  early_arm = 0;
    int  early_at  = 0;
    int  se_cnt0   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream generator: one beat every other clock, zero on generator slot 0.
    initial begin
        clk_en = 1'b0;
        zero   = 1'b0;
        eg_V   = '0;
        for (int i = 0; i < 24; i++) eg_tbl[i] = 10'(i * 16);
        forever begin
            @(negedge clk);
            phase = !phase;
            if (phase && !pause) begin
                if (early_arm && gslot == early_at) begin
                    gslot     = 0;
                    early_arm = 0;
                end
                clk_en = 1'b1;
                zero   = stream_on && (gslot == 0);
                eg_V   = eg_tbl[gslot];
                gslot  = (gslot == 23) ? 0 : gslot + 1;
            end else begin
                clk_en = 1'b0;
                zero   = 1'b0;
            end
        end
    end

    always @(negedge clk) if (sync_err0 === 1'b1) se_cnt0++;

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic start_read(input int d, input logic [4:0] s,
                              output int lat, output bit tmo);
        logic a;
        if (d == 0) begin bus0.req_slot = s; bus0.req = 1'b1; end
        else        begin bus3.req_slot = s; bus3.req = 1'b1; end
        lat = 0;
        tmo = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            lat++;
            a = (d == 0) ? bus0.ack : bus3.ack;
            if (a === 1'b1) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic end_read(input int d);
        if (d == 0) bus0.req = 1'b0; else bus3.req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++; if (bus0.ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", bus0.ack); end
        checks++; if (bus0.rd_eg !== 10'h000) begin errors++; $display("FAIL reset_rd_eg got %h want 000", bus0.rd_eg); end
        checks++; if (bus0.rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err got %b want 0", bus0.rd_err); end
        checks++; if (synced0 !== 1'b0) begin errors++; $display("FAIL reset_synced got %b want 0", synced0); end
        checks++; if (sync_err0 !== 1'b0) begin errors++; $display("FAIL reset_sync_err got %b want 0", sync_err0); end
        checks++; if (silent0 !== 24'hFFFFFF) begin errors++; $display("FAIL reset_silent got %h want ffffff", silent0); end
        // Beats with no zero marker must not touch the mask.
        wait_clks(60);
        checks++; if (silent0 !== 24'hFFFFFF) begin errors++; $display("FAIL unsynced_silent got %h want ffffff", silent0); end
        checks++; if (synced0 !== 1'b0) begin errors++; $display("FAIL unsynced_synced got %b want 0", synced0); end
    endtask

    task automatic test_sync;
        int base;
        base = se_cnt0;
        stream_on = 1;
        wait_clks(110);
        checks++; if (synced0 !== 1'b1) begin errors++; $display("FAIL sync_synced got %b want 1", synced0); end
        checks++; if (silent0 !== 24'h000000) begin errors++; $display("FAIL sync_silent got %h want 000000", silent0); end
        checks++; if (se_cnt0 - base !== 0) begin errors++; $display("FAIL sync_no_err got %0d want 0", se_cnt0 - base); end
    endtask

    task automatic test_read;
        int lat; bit tmo;
        start_read(0, 5'd5, lat, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL read5_timeout got %b want 0", tmo); end
        checks++; if (bus0.rd_eg !== 10'h050) begin errors++; $display("FAIL read5_eg got %h want 050", bus0.rd_eg); end
        checks++; if (bus0.rd_err !== 1'b0) begin errors++; $display("FAIL read5_err got %b want 0", bus0.rd_err); end
        checks++; if (lat > 50) begin errors++; $display("FAIL read5_latency got %0d want <=50", lat); end
        wait_clks(3);
        checks++; if (bus0.ack !== 1'b1) begin errors++; $display("FAIL read5_hold got %b want 1", bus0.ack); end
        checks++; if (bus0.rd_eg !== 10'h050) begin errors++; $display("FAIL read5_hold_eg got %h want 050", bus0.rd_eg); end
        end_read(0);
        checks++; if (bus0.ack !== 1'b0) begin errors++; $display("FAIL read5_fall got %b want 0", bus0.ack); end

        start_read(0, 5'd0, lat, tmo);
        checks++; if (tmo !== 1'b0 || bus0.rd_eg !== 10'h000) begin errors++; $display("FAIL read0_eg got %h tmo %b want 000", bus0.rd_eg, tmo); end
        end_read(0);
        start_read(0, 5'd23, lat, tmo);
        checks++; if (tmo !== 1'b0 || bus0.rd_eg !== 10'h170) begin errors++; $display("FAIL read23_eg got %h tmo %b want 170", bus0.rd_eg, tmo); end
        end_read(0);
    endtask

    task automatic test_offset;
        int lat; bit tmo;
        start_read(3, 5'd3, lat, tmo);
        checks++; if (tmo !== 1'b0 || bus3.rd_eg !== 10'h000) begin errors++; $display("FAIL ofs_slot3 got %h tmo %b want 000", bus3.rd_eg, tmo); end
        end_read(3);
        start_read(3, 5'd2, lat, tmo);
        checks++; if (tmo !== 1'b0 || bus3.rd_eg !== 10'h170) begin errors++; $display("FAIL ofs_slot2_wrap got %h tmo %b want 170", bus3.rd_eg, tmo); end
        end_read(3);
        start_read(3, 5'd10, lat, tmo);
        checks++; if (tmo !== 1'b0 || bus3.rd_eg !== 10'h070) begin errors++; $display("FAIL ofs_slot10 got %h tmo %b want 070", bus3.rd_eg, tmo); end
        end_read(3);
    endtask

    task automatic test_bad_slot;
        int lat; bit tmo;
        start_read(0, 5'd25, lat, tmo);
        checks++; if (lat !== 1 || tmo !== 1'b0) begin errors++; $display("FAIL bad_latency got %0d tmo %b want 1", lat, tmo); end
        checks++; if (bus0.rd_eg !== 10'h3FF) begin errors++; $display("FAIL bad_eg got %h want 3ff", bus0.rd_eg); end
        checks++; if (bus0.rd_err !== 1'b1) begin errors++; $display("FAIL bad_err got %b want 1", bus0.rd_err); end
        end_read(0);
        checks++; if (bus0.ack !== 1'b0) begin errors++; $display("FAIL bad_fall got %b want 0", bus0.ack); end
        start_read(0, 5'd1, lat, tmo);
        checks++; if (tmo !== 1'b0 || bus0.rd_eg !== 10'h010 || bus0.rd_err !== 1'b0) begin errors++; $display("FAIL b2b_read1 got %h err %b want 010 err 0", bus0.rd_eg, bus0.rd_err); end
        end_read(0);
    endtask

    task automatic test_resync;
        int base; int lat; bit tmo;
        base = se_cnt0;
        early_at  = 10;
        early_arm = 1;
        wait_clks(110);
        checks++; if (se_cnt0 - base !== 1) begin errors++; $display("FAIL resync_pulses got %0d want 1", se_cnt0 - base); end
        checks++; if (synced0 !== 1'b1) begin errors++; $display("FAIL resync_synced got %b want 1", synced0); end
        start_read(0, 5'd12, lat, tmo);
        checks++; if (tmo !== 1'b0 || bus0.rd_eg !== 10'h0C0) begin errors++; $display("FAIL resync_read12 got %h tmo %b want 0c0", bus0.rd_eg, tmo); end
        end_read(0);
        checks++; if (silent0 !== 24'h000000) begin errors++; $display("FAIL resync_silent got %h want 000000", silent0); end
    endtask

    task automatic test_silent_reset;
        int lat; bit tmo;
        eg_tbl[7] = 10'h3FF;
        wait_clks(110);
        checks++; if (silent0 !== 24'h000080) begin errors++; $display("FAIL silent7 got %h want 000080", silent0); end
        checks++; if (silent3 !== 24'h000400) begin errors++; $display("FAIL silent7_ofs got %h want 000400", silent3); end
        // Frozen stream: the request parks in WAIT.
        pause = 1;
        wait_clks(2);
        bus0.req_slot = 5'd5;
        bus0.req      = 1'b1;
        wait_clks(6);
        checks++; if (bus0.ack !== 1'b0) begin errors++; $display("FAIL frozen_wait_ack got %b want 0", bus0.ack); end
        rst_n = 1'b0;
        wait_clks(2);
        rst_n = 1'b1;
        checks++; if (bus0.ack !== 1'b0) begin errors++; $display("FAIL midreset_ack got %b want 0", bus0.ack); end
        checks++; if (silent0 !== 24'hFFFFFF) begin errors++; $display("FAIL midreset_silent got %h want ffffff", silent0); end
        checks++; if (synced0 !== 1'b0) begin errors++; $display("FAIL midreset_synced got %b want 0", synced0); end
        stream_on = 0;
        pause     = 0;
        wait_clks(80);
        checks++; if (bus0.ack !== 1'b0) begin errors++; $display("FAIL nozero_ack got %b want 0", bus0.ack); end
        stream_on = 1;
        start_read(0, 5'd5, lat, tmo);
        checks++; if (tmo !== 1'b0 || bus0.rd_eg !== 10'h050) begin errors++; $display("FAIL postreset_read5 got %h tmo %b want 050", bus0.rd_eg, tmo); end
        end_read(0);
        checks++; if (bus0.ack !== 1'b0) begin errors++; $display("FAIL postreset_fall got %b want 0", bus0.ack); end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus0.req      = 1'b0;
        bus0.req_slot = '0;
        bus3.req      = 1'b0;
        bus3.req_slot = '0;
        wait_clks(4);
        rst_n = 1'b1;
        wait_clks(1);
        test_reset();
        test_sync();
        test_read();
        test_offset();
        test_bad_slot();
        test_resync();
        test_silent_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
